// File: rtl/register_file_if.sv
// Bus bundle for the MIPS register file: decode read ports, write-back port
// and the valid/ready dump stream used by the debug/trace path.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic                  dump_start;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [ADDR_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_busy;
    logic                  dump_done;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, dump_start, dump_ready,
        input  rdata_a, rdata_b, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, dump_start, dump_ready,
        output rdata_a, rdata_b, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/register_file.sv
// MIPS register file: two bypassed combinational read ports, one write port,
// hardwired-zero $0, and a sequential dump engine streaming every register.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic [ADDR_WIDTH-1:0] dump_addr_reg, dump_addr_next;
    logic [DATA_WIDTH-1:0] dump_data_reg, dump_data_next;
    logic                  load_beat;
    logic [ADDR_WIDTH-1:0] load_idx;
    logic [DATA_WIDTH-1:0] load_data;

    // Zero for $0, write-through when the same address is being written this cycle.
    function automatic logic [DATA_WIDTH-1:0] bypass_read(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wr_en,
        input logic [ADDR_WIDTH-1:0] wr_addr,
        input logic [DATA_WIDTH-1:0] wr_data,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (addr == '0)
            return '0;
        else if (wr_en && (wr_addr == addr))
            return wr_data;
        else
            return stored;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst)
                    regs_reg[gi] <= '0;
                else if ((gi != 0) && bus.we && (bus.waddr == ADDR_WIDTH'(gi)))
                    regs_reg[gi] <= bus.wdata;
            end
        end
    endgenerate

    assign bus.rdata_a = bypass_read(bus.raddr_a, bus.we, bus.waddr, bus.wdata, regs_reg[bus.raddr_a]);
    assign bus.rdata_b = bypass_read(bus.raddr_b, bus.we, bus.waddr, bus.wdata, regs_reg[bus.raddr_b]);
    assign load_data   = bypass_read(load_idx,    bus.we, bus.waddr, bus.wdata, regs_reg[load_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            dump_addr_reg <= '0;
            dump_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            dump_addr_reg <= dump_addr_next;
            dump_data_reg <= dump_data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load_beat  = 1'b0;
        load_idx   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (bus.dump_start) begin
                    state_next = SEND;
                    idx_next   = '0;
                    load_beat  = 1'b1;
                    load_idx   = '0;
                end
            end
            SEND: begin
                if (bus.dump_ready) begin
                    // Termination is the compare at the last index; idx never wraps.
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next  = idx_reg + 1'b1;
                        load_beat = 1'b1;
                        load_idx  = idx_reg + 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The beat is a per-beat snapshot: it only changes on a load edge.
    assign dump_addr_next = load_beat ? load_idx  : dump_addr_reg;
    assign dump_data_next = load_beat ? load_data : dump_data_reg;

    assign bus.dump_addr  = dump_addr_reg;
    assign bus.dump_data  = dump_data_reg;
    assign bus.dump_valid = (state_reg == SEND);
    assign bus.dump_busy  = (state_reg != IDLE);
    assign bus.dump_done  = (state_reg == DONE);
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: storage, bypass, $0,
// full dumps with and without back-pressure, and reset mid-dump.
module tb_register_file;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int done_cyc;
        int done_pulses;

        rst            = 1'b1;
        bus.we         = 1'b0;
        bus.waddr      = '0;
        bus.wdata      = '0;
        bus.raddr_a    = 5'd3;
        bus.raddr_b    = 5'd31;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_valid", 32'(bus.dump_valid), 32'd0);
        check("reset_busy",  32'(bus.dump_busy),  32'd0);
        check("reset_done",  32'(bus.dump_done),  32'd0);
        check("reset_addr",  32'(bus.dump_addr),  32'd0);
        check("reset_data",  bus.dump_data,       32'd0);
        check("reset_rdata_a", bus.rdata_a,       32'd0);
        check("reset_rdata_b", bus.rdata_b,       32'd0);
        $display("reset released");

        // Plain write then read from storage
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        tick();
        bus.we = 1'b0; bus.raddr_a = 5'd5; bus.raddr_b = 5'd0;
        #1;
        check("read_r5", bus.rdata_a, 32'hDEADBEEF);
        check("read_r0", bus.rdata_b, 32'd0);
        $display("write r5 = deadbeef, read back %h", bus.rdata_a);

        // Write to $0 is discarded, even through the bypass
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h00001234; bus.raddr_a = 5'd0;
        #1;
        check("r0_same_cycle", bus.rdata_a, 32'd0);
        tick();
        bus.we = 1'b0;
        #1;
        check("r0_after", bus.rdata_a, 32'd0);
        $display("write r0 = 1234 discarded");

        // Write-through bypass on both ports
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5A5A5A5;
        bus.raddr_a = 5'd7; bus.raddr_b = 5'd7;
        #1;
        check("bypass_a", bus.rdata_a, 32'hA5A5A5A5);
        check("bypass_b", bus.rdata_b, 32'hA5A5A5A5);
        tick();
        bus.we = 1'b0;
        #1;
        check("r7_stored", bus.rdata_a, 32'hA5A5A5A5);
        $display("bypass r7 = a5a5a5a5");

        // Fill reg[i] = i*3
        for (int i = 1; i < 32; i++) begin
            bus.we = 1'b1; bus.waddr = 5'(i); bus.wdata = 32'(i * 3);
            tick();
        end
        bus.we = 1'b0;
        bus.raddr_a = 5'd31;
        #1;
        check("fill_r31", bus.rdata_a, 32'd93);
        $display("filled reg[i] = i*3");

        // Dump with ready held high
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        #1;
        check("dump1_busy_t", 32'(bus.dump_busy), 32'd0);
        tick();
        bus.dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            check("dump1_valid", 32'(bus.dump_valid), 32'd1);
            check("dump1_addr",  32'(bus.dump_addr),  32'(b));
            check("dump1_data",  bus.dump_data,       32'(b * 3));
            tick();
        end
        check("dump1_done",       32'(bus.dump_done),  32'd1);
        check("dump1_done_busy",  32'(bus.dump_busy),  32'd1);
        check("dump1_done_valid", 32'(bus.dump_valid), 32'd0);
        tick();
        check("dump1_done_after", 32'(bus.dump_done), 32'd0);
        check("dump1_busy_after", 32'(bus.dump_busy), 32'd0);
        $display("dump 1 complete: 32 beats");

        // Dump with ready toggling, reg[3] rewritten while beat 3 stalls,
        // and a stray dump_start mid-dump
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        k = 0;
        done_cyc = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus.dump_ready = (cyc % 2 == 0);
            bus.dump_start = (cyc == 10);
            bus.we    = (k == 3) && (cyc % 2 == 1);
            bus.waddr = 5'd3;
            bus.wdata = 32'h0000FFFF;
            #1;
            if (bus.dump_done) begin
                done_cyc = cyc;
                break;
            end
            check("dump2_valid", 32'(bus.dump_valid), 32'd1);
            if (bus.dump_valid) begin
                check("dump2_addr", 32'(bus.dump_addr), 32'(k));
                check("dump2_data", bus.dump_data,      32'(k * 3));
                if (bus.dump_ready) k++;
            end
            tick();
        end
        bus.we = 1'b0; bus.dump_start = 1'b0; bus.dump_ready = 1'b1;
        check("dump2_done_cycle", 32'(done_cyc), 32'd63);
        check("dump2_beats",      32'(k),        32'd32);
        tick();
        check("dump2_busy_after", 32'(bus.dump_busy), 32'd0);
        check("dump2_done_after", 32'(bus.dump_done), 32'd0);
        bus.raddr_a = 5'd3;
        #1;
        check("r3_rewritten", bus.rdata_a, 32'h0000FFFF);
        $display("dump 2 complete: %0d beats, done at cycle %0d", k, done_cyc);

        // Reset while beat 10 is pending, together with a write
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        repeat (10) tick();
        bus.dump_ready = 1'b0;
        #1;
        check("rst_beat10_addr", 32'(bus.dump_addr), 32'd10);
        check("rst_beat10_data", bus.dump_data,      32'd30);
        rst = 1'b1; bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h00000099;
        tick();
        rst = 1'b0; bus.we = 1'b0;
        bus.raddr_a = 5'd9; bus.raddr_b = 5'd5;
        #1;
        check("rst_valid", 32'(bus.dump_valid), 32'd0);
        check("rst_busy",  32'(bus.dump_busy),  32'd0);
        check("rst_done",  32'(bus.dump_done),  32'd0);
        check("rst_addr",  32'(bus.dump_addr),  32'd0);
        check("rst_data",  bus.dump_data,       32'd0);
        check("rst_r9",    bus.rdata_a,         32'd0);
        check("rst_r5",    bus.rdata_b,         32'd0);
        bus.dump_ready = 1'b1;
        done_pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.dump_done) done_pulses++;
            tick();
        end
        check("rst_no_done", 32'(done_pulses), 32'd0);
        $display("reset mid-dump handled");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
